// File: rtl/fetch_stage_pkg.sv
// Shared ARM pipeline definitions for the fetch stage.
//   AddrW / InstW : default address and instruction widths
//   NopInst       : instruction word used as a pipeline bubble
//   if_id_t       : IF/ID payload {pc, inst, valid} at default widths
package fetch_stage_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned InstW = 32;

    localparam logic [InstW-1:0] NopInst = '0;

    typedef struct packed {
        logic [AddrW-1:0] pc;
        logic [InstW-1:0] inst;
        logic             valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr  : fetch address (driven by master)
//   imem_data  : instruction word for imem_addr, same cycle (driven by slave)
//   imem_ready : imem_data valid this cycle (driven by slave)
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned INST_W = InstW
);

    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              imem_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output imem_ready
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold and flush controls.
//   clk, rst      : clock, synchronous active-low reset
//   hold_i        : keep current contents
//   flush_i       : load a bubble {0, NOP_INST, valid=0}; wins over hold_i
//   pc_i, inst_i  : payload loaded when neither hold nor flush
//   pc_o, inst_o, valid_o : registered contents
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned            ADDR_W   = AddrW,
    parameter int unsigned            INST_W   = InstW,
    parameter logic [INST_W-1:0]      NOP_INST = NopInst
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = '0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ARM pipeline instruction-fetch stage with IF/ID register.
//   clk, rst      : clock, synchronous active-low reset
//   freeze        : hazard stall, hold PC and IF/ID
//   branch_taken  : EXE-resolved branch, redirect PC to branch_addr and flush IF/ID
//   branch_addr   : branch target (not alignment-checked)
//   imem          : instruction-memory bus (imem_addr = pc, combinational)
//   if_id_pc      : registered PC+4 of the latched instruction
//   if_id_inst    : registered instruction
//   if_id_valid   : IF/ID holds a real instruction
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = AddrW,
    parameter int unsigned       INST_W   = InstW,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = NopInst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    fetch_stage_if.master      imem,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INST_W-1:0]  if_id_inst,
    output logic               if_id_valid
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic              if_id_hold;
    logic              if_id_flush;

    // Wraps modulo 2^ADDR_W.
    assign pc_plus4       = pc_q + ADDR_W'(4);
    assign imem.imem_addr = pc_q;

    // Priority: branch > freeze > not-ready > advance.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_addr;
        end else if (!freeze && imem.imem_ready) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A missing instruction only bubbles IF/ID when not frozen; a branch always flushes.
    assign if_id_flush = branch_taken || (!freeze && !imem.imem_ready);
    assign if_id_hold  = freeze;

    fetch_stage_if_id_reg #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (if_id_hold),
        .flush_i (if_id_flush),
        .pc_i    (pc_plus4),
        .inst_i  (imem.imem_data),
        .pc_o    (if_id_pc),
        .inst_o  (if_id_inst),
        .valid_o (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns 0xE000_0000 | addr.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;

    int unsigned n_cmp;
    int unsigned n_err;

    fetch_stage_if #(.ADDR_W(32), .INST_W(32)) imem_bus ();

    assign imem_bus.imem_data = 32'hE000_0000 | imem_bus.imem_addr;

    fetch_stage #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0),
        .NOP_INST (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem_bus.master),
        .if_id_pc     (if_id_pc),
        .if_id_inst   (if_id_inst),
        .if_id_valid  (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the whole visible state against a hand-computed IF/ID payload and PC.
    task automatic check_state(input string tag, input logic [31:0] exp_addr, input if_id_t exp);
        check_eq({tag, ".addr"},  imem_bus.imem_addr, exp_addr);
        check_eq({tag, ".pc"},    if_id_pc,           exp.pc);
        check_eq({tag, ".inst"},  if_id_inst,         exp.inst);
        check_eq({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, exp.valid});
    endtask

    localparam if_id_t Bubble = '{pc: 32'h0, inst: 32'h0, valid: 1'b0};

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_bus.imem_ready = 1'b1;

        // Reset
        step();
        check_state("reset", 32'h0, Bubble);
        rst = 1'b1;

        // Sequential fetch
        step();
        check_state("seq0", 32'h4, '{32'h4, 32'hE000_0000, 1'b1});
        step();
        check_state("seq1", 32'h8, '{32'h8, 32'hE000_0004, 1'b1});

        // Freeze at pc=8 for two cycles
        freeze = 1'b1;
        step();
        check_state("frz0", 32'h8, '{32'h8, 32'hE000_0004, 1'b1});
        step();
        check_state("frz1", 32'h8, '{32'h8, 32'hE000_0004, 1'b1});
        freeze = 1'b0;
        step();
        check_state("resume0", 32'hC, '{32'hC, 32'hE000_0008, 1'b1});
        step();
        check_state("resume1", 32'h10, '{32'h10, 32'hE000_000C, 1'b1});

        // Branch overrides freeze
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        freeze       = 1'b1;
        step();
        check_state("br", 32'h100, Bubble);
        branch_taken = 1'b0;
        freeze       = 1'b0;
        step();
        check_state("br_next", 32'h104, '{32'h104, 32'hE000_0100, 1'b1});

        // Back-to-back branches, unaligned target passes through, last wins
        branch_taken = 1'b1;
        branch_addr  = 32'h203;
        step();
        check_state("br2a", 32'h203, Bubble);
        branch_addr = 32'h20;
        step();
        check_state("br2b", 32'h20, Bubble);
        branch_taken = 1'b0;

        // imem not ready for 3 cycles at pc=0x20
        imem_bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("nrdy", 32'h20, Bubble);
        end
        // Freeze on a bubble keeps the bubble
        freeze = 1'b1;
        step();
        check_state("frz_bub", 32'h20, Bubble);
        freeze              = 1'b0;
        imem_bus.imem_ready = 1'b1;
        step();
        check_state("rdy", 32'h24, '{32'h24, 32'hE000_0020, 1'b1});

        // PC wrap at the top of the address space
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        check_state("wrap_br", 32'hFFFF_FFFC, Bubble);
        branch_taken = 1'b0;
        step();
        check_state("wrap", 32'h0, '{32'h0, 32'hFFFF_FFFC, 1'b1});

        // Reset during freeze at pc=0x40
        branch_taken = 1'b1;
        branch_addr  = 32'h3C;
        step();
        branch_taken = 1'b0;
        step();
        check_state("pre_rst", 32'h40, '{32'h40, 32'hE000_003C, 1'b1});
        freeze = 1'b1;
        step();
        rst = 1'b0;
        #2;
        check_state("rst_pending", 32'h40, '{32'h40, 32'hE000_003C, 1'b1});
        step();
        check_state("rst_frz", 32'h0, Bubble);
        rst    = 1'b1;
        freeze = 1'b0;
        step();
        check_state("post_rst", 32'h4, '{32'h4, 32'hE000_0000, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
